// File: rtl/rv_pkg.sv
// Shared definitions for the RV instruction fetch slice.
// Purpose: data width, instruction size and PC alignment constants that the
//          fetch top and anything downstream of it agree on.
// Contents:
//   XLEN          architectural register / address width
//   INST_BYTES    size of one fetched instruction word in bytes
//   NOP           canonical no-op encoding (addi x0, x0, 0)
//   PC_ALIGN_MASK clears the byte offset inside an instruction word
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

endpackage

// File: rtl/rv_fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch stage.
// Purpose: registered storage with a combinational head read, synchronous
//          flush, and push+pop in the same cycle even when full.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   push_i   in   write wdata_i at the tail (ignored when full without pop)
//   wdata_i  in   WIDTH-bit entry to write
//   pop_i    in   drop the head entry (ignored when empty)
//   flush_i  in   empty the queue; takes priority over push/pop
//   rdata_o  out  current head entry
//   count_o  out  number of valid entries, 0..DEPTH
module rv_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees the slot the simultaneous push lands in, so a full queue
  // can still accept a write in the same cycle it hands its head off.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch stage.
// Purpose: owns the PC, issues word reads to instruction memory under a
//          credit limit, and returns {pc, inst} pairs in order to decode.
//          A redirect flushes queued instructions and drops every response
//          still in flight.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   imem_req_*      read request (valid/ready, word-aligned addr)
//   imem_rsp_*      read response, in order, never stalled
//   redirect_*      one-cycle control-flow change and its target PC
//   out_*           {pc, inst} to decode (valid/ready)
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     inst_cnt, inflight_cnt;
  logic [CW:0]       credit_used;
  logic [XLEN-1:0]   rsp_pc;
  logic [2*XLEN-1:0] head;
  logic              accept, rsp_fire, rsp_keep, out_pop;

  // Credits count both queued and in-flight words, so every response is
  // guaranteed a slot in the instruction queue when it lands.
  always_comb begin
    credit_used    = {1'b0, inst_cnt} + {1'b0, outstanding_q};
    imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && !rst;
    rsp_keep       = rsp_fire && !redirect_valid && (drop_cnt_q == '0);
    out_valid      = !rst && (inst_cnt != '0);
    out_pop        = out_valid && out_ready;
    out_pc         = head[2*XLEN-1:XLEN];
    out_inst       = head[XLEN-1:0];
  end

  // Next PC, in-flight count and drop count. A response arriving in the
  // redirect cycle belongs to the old path, so it is subtracted from the
  // drop count and discarded right away.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc & PC_ALIGN_MASK;
      drop_cnt_d = outstanding_q - CW'(rsp_fire);
    end else begin
      if (accept) pc_d = pc_q + XLEN'(INST_BYTES);
      if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // PCs of requests still waiting on memory; pairs each response with its
  // address. Never flushed because dropped responses must still pop it.
  rv_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (pc_q),
    .pop_i   (rsp_fire),
    .flush_i (1'b0),
    .rdata_o (rsp_pc),
    .count_o (inflight_cnt)
  );

  // Fetched {pc, inst} pairs awaiting decode; cleared on redirect.
  rv_fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_keep),
    .wdata_i ({rsp_pc, imem_rsp_data}),
    .pop_i   (out_pop),
    .flush_i (redirect_valid),
    .rdata_o (head),
    .count_o (inst_cnt)
  );

  // Protocol and credit sanity checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (outstanding_q == '0)));
      assert (credit_used <= (CW+1)'(FIFO_DEPTH));
      assert (inflight_cnt == outstanding_q);
    end
  end

endmodule

// File: tb/tb_rv_fetch.sv
// Directed testbench for rv_fetch with a fixed-latency memory model.
module tb_rv_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int          passed = 0;
  int          total  = 0;
  int          memLat = 1;
  int          cyc    = 0;
  logic [31:0] pendAddr [$];
  int          pendDue  [$];
  logic [63:0] outLog   [$];
  logic [31:0] reqLog   [$];

  rv_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_50b7;
      32'h0000_0004: return 32'h0000_0137;
      32'h0000_0008: return 32'h0050_8193;
      32'h0000_0100: return 32'h00a0_0093;
      default:       return {a[15:0], 16'h0013};
    endcase
  endfunction

  // Memory model: records accepted requests at the edge and drives the
  // matching response memLat edges later, set up just after each edge.
  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pendAddr.delete();
      pendDue.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pendAddr.push_back(imem_req_addr);
      pendDue.push_back(cyc + memLat);
    end
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pendDue.size() > 0 && pendDue[0] == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pendAddr[0]);
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end
  end

  // Logs every decode handshake and every accepted request.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) outLog.push_back({out_pc, out_inst});
    if (!rst && imem_req_valid && imem_req_ready) reqLog.push_back(imem_req_addr);
  end

  function automatic logic [31:0] logPc(input int i);
    return (outLog.size() > i) ? outLog[i][63:32] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] logInst(input int i);
    return (outLog.size() > i) ? outLog[i][31:0] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] reqAt(input int i);
    return (reqLog.size() > i) ? reqLog[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic reqRdy, input logic outRdy,
                               input logic redir, input logic [31:0] redirPc);
    rst            = r;
    imem_req_ready = reqRdy;
    out_ready      = outRdy;
    redirect_valid = redir;
    redirect_pc    = redirPc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic doReset(input int lat);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    memLat = lat;
    repeat (2) tick();
    outLog.delete();
    reqLog.delete();
  endtask

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // Reset state and straight-line fetch with 1-cycle memory.
    doReset(1);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);
    tick();
    checkOutput("out_valid_n1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("out_valid_n2", 32'(out_valid), 32'd1);
    repeat (6) tick();
    checkOutput("seq_pc0", logPc(0), 32'h0);
    checkOutput("seq_inst0", logInst(0), 32'h0000_50b7);
    checkOutput("seq_pc1", logPc(1), 32'h4);
    checkOutput("seq_inst1", logInst(1), 32'h0000_0137);
    checkOutput("seq_pc2", logPc(2), 32'h8);
    checkOutput("seq_inst2", logInst(2), 32'h0050_8193);

    // Decode stalled: credits stop fetch after FIFO_DEPTH requests.
    doReset(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) tick();
    checkOutput("stall_req_count", 32'(reqLog.size()), 32'd2);
    checkOutput("stall_req_addr1", reqAt(1), 32'h4);
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall_out_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (10) tick();
    checkOutput("resume_pc0", logPc(0), 32'h0);
    checkOutput("resume_pc1", logPc(1), 32'h4);
    checkOutput("resume_pc2", logPc(2), 32'h8);
    checkOutput("resume_pc3", logPc(3), 32'hC);
    checkOutput("resume_req2", reqAt(2), 32'h8);

    // Memory not ready: request held stable.
    doReset(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("hold_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("hold_addr", imem_req_addr, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (5) tick();
    checkOutput("hold_first_pc", logPc(0), 32'h0);
    checkOutput("hold_first_inst", logInst(0), 32'h0000_50b7);

    // Redirect with two requests in flight on 3-cycle memory.
    doReset(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    #1;
    checkOutput("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("redir_new_addr", imem_req_addr, 32'h100);
    repeat (12) tick();
    checkOutput("redir_pc0", logPc(0), 32'h100);
    checkOutput("redir_inst0", logInst(0), 32'h00a0_0093);
    checkOutput("redir_pc1", logPc(1), 32'h104);
    begin
      int stale = 0;
      foreach (outLog[i]) if (outLog[i][63:32] < 32'h100) stale++;
      checkOutput("redir_no_stale", 32'(stale), 32'd0);
    end

    // Redirect to unaligned target coincident with response and handoff.
    doReset(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h103);
    #1;
    checkOutput("coin_out_valid", 32'(out_valid), 32'd1);
    checkOutput("coin_out_pc", out_pc, 32'h0);
    checkOutput("coin_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("coin_req_addr", imem_req_addr, 32'h100);
    checkOutput("coin_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("coin_flushed", 32'(out_valid), 32'd0);
    repeat (6) tick();
    checkOutput("coin_kept_pc", logPc(0), 32'h0);
    checkOutput("coin_next_pc", logPc(1), 32'h100);
    checkOutput("coin_next_inst", logInst(1), 32'h00a0_0093);

    // Reset pulsed in the middle of traffic.
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    outLog.delete();
    reqLog.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("midrst_req_addr", imem_req_addr, 32'h0);
    repeat (6) tick();
    checkOutput("midrst_pc0", logPc(0), 32'h0);
    checkOutput("midrst_inst0", logInst(0), 32'h0000_50b7);
    checkOutput("midrst_pc1", logPc(1), 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
